// File: rtl/man_motion_controller.sv
// Per-frame player position and vertical physics engine. ManY moves one pixel per
// clock so the external row-exact collision check (on_ground) can never be skipped.
module man_motion_controller #(
  parameter int X_START = 10,
  parameter int Y_START = 215,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 619,
  parameter int Y_MAX   = 479,
  parameter int STEP_X  = 1,
  parameter int JUMP_V  = 8,
  parameter int V_MAX   = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       on_ground,
  output logic [9:0] ManX,
  output logic [9:0] ManY,
  output logic [1:0] mode,
  output logic       busy,
  output logic       respawn
);

  typedef enum logic [1:0] {S_WAIT, S_HMOVE, S_VSTEP, S_VEND} state_e;
  typedef enum logic [1:0] {M_GROUND = 2'b00, M_RISE = 2'b01, M_FALL = 2'b10} mode_e;

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] vel_q, vel_d, rem_q, rem_d;
  logic       kl_q, kl_d, kr_q, kr_d, kj_q, kj_d;
  logic       resp_q, resp_d;

  function automatic logic [9:0] sat_x(input logic [9:0] x, input logic l, input logic r);
    int nx;
    nx = int'(x);
    if (r && !l) nx = nx + STEP_X;
    else if (l && !r) nx = nx - STEP_X;
    if (nx < X_MIN) nx = X_MIN;
    if (nx > X_MAX) nx = X_MAX;
    return 10'(nx);
  endfunction

  function automatic logic [3:0] fall_vel_inc(input logic [3:0] v);
    if (v >= 4'(V_MAX)) return 4'(V_MAX);
    return v + 4'd1;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_WAIT;
      mode_q  <= M_GROUND;
      x_q     <= 10'(X_START);
      y_q     <= 10'(Y_START);
      vel_q   <= 4'd0;
      rem_q   <= 4'd0;
      kl_q    <= 1'b0;
      kr_q    <= 1'b0;
      kj_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      rem_q   <= rem_d;
      kl_q    <= kl_d;
      kr_q    <= kr_d;
      kj_q    <= kj_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    rem_d   = rem_q;
    kl_d    = kl_q;
    kr_d    = kr_q;
    kj_d    = kj_q;
    resp_d  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (frame_tick) begin
          kl_d    = key_left;
          kr_d    = key_right;
          kj_d    = key_jump;
          state_d = S_HMOVE;
        end
      end
      S_HMOVE: begin
        x_d   = sat_x(x_q, kl_q, kr_q);
        rem_d = vel_q;
        // Walking off an edge is detected in VSTEP, once on_ground reflects the new X.
        if (mode_q == M_GROUND && kj_q) begin
          mode_d = M_RISE;
          vel_d  = 4'(JUMP_V);
          rem_d  = 4'(JUMP_V);
        end
        state_d = S_VSTEP;
      end
      S_VSTEP: begin
        case (mode_q)
          M_GROUND: begin
            if (on_ground) begin
              state_d = S_VEND;
            end else begin
              mode_d = M_FALL;
              vel_d  = 4'd1;
              rem_d  = 4'd1;
            end
          end
          M_RISE: begin
            if (rem_q == 4'd0 || y_q == 10'd0) begin
              state_d = S_VEND;
            end else begin
              y_d   = y_q - 10'd1;
              rem_d = rem_q - 4'd1;
            end
          end
          default: begin
            // Landing is tested before every pixel so a platform row is never crossed.
            if (on_ground) begin
              mode_d  = M_GROUND;
              vel_d   = 4'd0;
              state_d = S_VEND;
            end else if (rem_q == 4'd0) begin
              state_d = S_VEND;
            end else begin
              y_d   = y_q + 10'd1;
              rem_d = rem_q - 4'd1;
            end
          end
        endcase
      end
      S_VEND: begin
        case (mode_q)
          M_RISE: begin
            if (y_q == 10'd0 || vel_q <= 4'd1) begin
              mode_d = M_FALL;
              vel_d  = 4'd1;
            end else begin
              vel_d = vel_q - 4'd1;
            end
          end
          M_FALL:  vel_d = fall_vel_inc(vel_q);
          default: ;
        endcase
        if (y_q > 10'(Y_MAX)) begin
          x_d    = 10'(X_START);
          y_d    = 10'(Y_START);
          mode_d = M_GROUND;
          vel_d  = 4'd0;
          resp_d = 1'b1;
        end
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  assign ManX    = x_q;
  assign ManY    = y_q;
  assign mode    = mode_q;
  assign busy    = (state_q != S_WAIT);
  assign respawn = resp_q;

endmodule

// File: tb/tb_man_motion_controller.sv
// Scoreboard bench for man_motion_controller with a two-platform world model
// (row 215 for X 0..33, row 314 for X 31..400).
module tb_man_motion_controller;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic       on_ground;
  logic [9:0] ManX, ManY;
  logic [1:0] mode;
  logic       busy, respawn;

  man_motion_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .on_ground(on_ground), .ManX(ManX), .ManY(ManY), .mode(mode),
    .busy(busy), .respawn(respawn)
  );

  always #5 Clk = ~Clk;

  assign on_ground = (ManY == 10'd215 && ManX <= 10'd33) ||
                     (ManY == 10'd314 && ManX >= 10'd31 && ManX <= 10'd400);

  typedef struct {
    int x;
    int y;
    int m;
    int r;
    int len;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   resp_cnt = 0;
  logic bprev = 1'b0;
  int   blen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a frame completes when busy falls; compare against the oldest expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      bprev = 1'b0;
      blen  = 0;
    end else begin
      if (respawn) resp_cnt++;
      if (busy) begin
        blen++;
      end else if (bprev) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got completion at X=%0d Y=%0d, expected none", ManX, ManY);
        end else begin
          e = q.pop_front();
          chk("frame_x", int'(ManX), e.x);
          chk("frame_y", int'(ManY), e.y);
          chk("frame_mode", int'(mode), e.m);
          chk("frame_respawn", int'(respawn), e.r);
          if (e.len >= 0) chk("frame_busy_len", blen, e.len);
        end
        blen = 0;
      end
      bprev = busy;
    end
  end

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("frame_timeout", 1, 0);
    @(negedge Clk); #1;
  endtask

  task automatic frame(input logic l, input logic r, input logic j,
                       input int ex, input int ey, input int em, input int er, input int elen);
    exp_t e;
    e.x = ex; e.y = ey; e.m = em; e.r = er; e.len = elen;
    q.push_back(e);
    @(posedge Clk); #1;
    key_left = l; key_right = r; key_jump = j; frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0; key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
    wait_idle();
  endtask

  int rise_y[8] = '{207, 200, 194, 189, 185, 182, 180, 179};
  int fall_y[8] = '{180, 182, 185, 189, 194, 200, 207, 215};
  int walk_y[16] = '{216, 218, 221, 225, 230, 236, 243, 251,
                     259, 267, 275, 283, 291, 299, 307, 314};
  int drop_y[7] = '{317, 320, 324, 329, 335, 342, 350};

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_x", int'(ManX), 10);
    chk("rst_y", int'(ManY), 215);
    chk("rst_mode", int'(mode), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_respawn", int'(respawn), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 5; i++) frame(0, 0, 0, 10, 215, 0, 0, 3);

    // Jump: 8 rise frames to 179, then fall back onto row 215
    for (int i = 0; i < 8; i++)
      frame(0, 0, (i == 0), 10, rise_y[i], (i == 7) ? 2 : 1, 0, (i == 0) ? 11 : -1);
    for (int i = 0; i < 8; i++)
      frame(0, 0, 0, 10, fall_y[i], (i == 7) ? 0 : 2, 0, -1);
    frame(0, 0, 0, 10, 215, 0, 0, 3);

    // Clamp at X_MIN and simultaneous keys
    for (int i = 9; i >= 0; i--) frame(1, 0, 0, i, 215, 0, 0, 3);
    frame(1, 0, 0, 0, 215, 0, 0, 3);
    frame(1, 0, 0, 0, 215, 0, 0, 3);
    frame(1, 1, 0, 0, 215, 0, 0, 3);

    // Walk to the edge of row 215, then step off and fall to row 314
    for (int i = 1; i <= 33; i++) frame(0, 1, 0, i, 215, 0, 0, 3);
    frame(1, 1, 0, 33, 215, 0, 0, 3);
    for (int i = 0; i < 16; i++)
      frame(0, (i == 0), 0, 34, walk_y[i], (i == 15) ? 0 : 2, 0,
            (i == 0) ? 5 : ((i == 15) ? 10 : -1));
    frame(0, 0, 0, 34, 314, 0, 0, 3);

    // A tick arriving while busy is dropped
    begin
      exp_t e;
      e.x = 34; e.y = 314; e.m = 0; e.r = 0; e.len = 3;
      q.push_back(e);
      @(posedge Clk); #1;
      frame_tick = 1'b1;
      @(posedge Clk); #1;
      key_right = 1'b1;
      @(posedge Clk); #1;
      frame_tick = 1'b0; key_right = 1'b0;
      wait_idle();
      repeat (10) @(posedge Clk);
      #1;
      chk("drop_busy", int'(busy), 0);
      chk("drop_x", int'(ManX), 34);
    end

    // Walk off the far end of row 314 and fall out of bounds
    for (int i = 35; i <= 400; i++) frame(0, 1, 0, i, 314, 0, 0, 3);
    frame(0, 1, 0, 401, 315, 2, 0, -1);
    for (int i = 0; i < 7; i++) frame(0, 0, 0, 401, drop_y[i], 2, 0, -1);
    for (int y = 358; y <= 478; y += 8) frame(0, 0, 0, 401, y, 2, 0, -1);
    frame(0, 0, 0, 10, 215, 0, 1, -1);
    frame(0, 0, 0, 10, 215, 0, 0, 3);
    chk("respawn_pulses", resp_cnt, 1);

    // Reset asserted mid-rise takes effect without waiting for a clock
    @(posedge Clk); #1;
    key_jump = 1'b1; frame_tick = 1'b1;
    @(posedge Clk); #1;
    key_jump = 1'b0; frame_tick = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    chk("mid_y_before", int'(ManY), 213);
    chk("mid_mode_before", int'(mode), 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_x", int'(ManX), 10);
    chk("mid_rst_y", int'(ManY), 215);
    chk("mid_rst_mode", int'(mode), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    frame(0, 0, 0, 10, 215, 0, 0, 3);

    repeat (4) @(posedge Clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
